seg7_scan_display: RTL and testbench

// - Parametrised time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
// - Sits between game logic (score/timer BCD or hex nibbles) and the board pins.
// - Adds the following on top of the simple 4-digit scan:
//   - refresh prescaler, inter-digit ghost blanking and per-frame snapshot (no tearing);
//   - hex glyphs, decimal points, per-digit blank and leading-zero blanking.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_font_rom.sv | 12 +
 rtl/seg7_scan_display.sv | 183 ++++++++++++++++++
 tb/tb_seg7_scan_display.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the active-high glyph table for the 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg7_glyph_t;

    localparam seg7_glyph_t SEG7_OFF = 7'h00;

    localparam seg7_glyph_t SEG7_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_font_rom.sv
// Combinational nibble to active-high glyph lookup (0-9, A, b, C, d, E, F).
// Pin polarity is applied by the caller.
module seg7_font_rom
    import seg7_pkg::*;
(
    input  logic [3:0]  nibble,
    output seg7_glyph_t glyph
);

    assign glyph = SEG7_FONT[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit 7-segment driver with prescaler, ghost gap, frame snapshot,
// blanking and leading-zero suppression. Optional per-digit blink when BLINK_EN is defined.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST_GAP   = 16,
    parameter bit ACTIVE_LOW  = 1'b1
`ifdef BLINK_EN
    ,
    parameter int BLINK_FRAMES = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_blank_en,
`ifdef BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GHOST_GAP);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // XOR masks that turn active-high internal values into pin levels
    localparam logic [NUM_DIGITS-1:0] AN_OFF_PIN  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF_PIN = {7{ACTIVE_LOW}};
    localparam logic                  DP_OFF_PIN  = ACTIVE_LOW;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
    logic                    snap_lz_q, snap_lz_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_start_q, frame_start_d;

    logic                    boundary;
    logic                    slot_end;
    logic                    in_gap;
    logic                    digit_dark;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0]   lz_dark;
    logic [NUM_DIGITS-1:0]   blink_dark;
    logic [NUM_DIGITS-1:0]   an_hi;
    logic [6:0]              seg_hi;
    logic                    dp_hi;
    logic [3:0]              cur_nib;
    seg7_glyph_t             cur_glyph;

    assign boundary = (cnt_q == '0) && (idx_q == '0);
    assign slot_end = (cnt_q == CNT_LAST);
    assign cur_nib  = snap_digits_q[4*int'(idx_q) +: 4];

    seg7_font_rom u_font (
        .nibble (cur_nib),
        .glyph  (cur_glyph)
    );

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        snap_digits_d = boundary ? digits      : snap_digits_q;
        snap_dp_d     = boundary ? dp_in       : snap_dp_q;
        snap_blank_d  = boundary ? blank       : snap_blank_q;
        snap_lz_d     = boundary ? lz_blank_en : snap_lz_q;
        frame_start_d = boundary;
    end

    // Walk down from the leftmost digit; a nonzero digit or a dp request ends the run.
    always_comb begin
        lz_dark = '0;
        lz_run  = snap_lz_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && (snap_digits_q[4*i +: 4] == 4'h0) && !snap_dp_q[i]) begin
                lz_dark[i] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
    end

`ifdef BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] snap_blink_q, snap_blink_d;
    logic [BF_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic                  phase_q, phase_d;

    // Phase advances on the last cycle of a frame so a whole frame sees one phase.
    always_comb begin
        snap_blink_d = boundary ? blink : snap_blink_q;
        frame_cnt_d  = frame_cnt_q;
        phase_d      = phase_q;
        if (slot_end && (idx_q == IDX_LAST)) begin
            if (frame_cnt_q == BF_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        blink_dark = phase_q ? snap_blink_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_blink_q <= '0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
        end else begin
            snap_blink_q <= snap_blink_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
        end
    end
`else
    assign blink_dark = '0;
`endif

    always_comb begin
        in_gap     = (cnt_q < CNT_GAP);
        digit_dark = snap_blank_q[idx_q] | lz_dark[idx_q] | blink_dark[idx_q];
        an_hi      = '0;
        if (!in_gap) begin
            an_hi[idx_q] = 1'b1;
        end
        seg_hi = (in_gap || digit_dark) ? SEG7_OFF : cur_glyph;
        dp_hi  = !in_gap && !digit_dark && snap_dp_q[idx_q];
        an_d   = an_hi ^ AN_OFF_PIN;
        seg_d  = seg_hi ^ SEG_OFF_PIN;
        dp_d   = dp_hi ^ DP_OFF_PIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '0;
            snap_lz_q     <= 1'b0;
            an_q          <= AN_OFF_PIN;
            seg_q         <= SEG_OFF_PIN;
            dp_q          <= DP_OFF_PIN;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_blank_q  <= snap_blank_d;
            snap_lz_q     <= snap_lz_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display (4 digits, 4-cycle slots, 1-cycle gap, active-low).
// Expected pin values per frame cycle are queued, then popped as the DUT scans.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic        lz_blank_en = 1'b0;
`ifdef BLINK_EN
    logic [3:0]  blink = '0;
`endif
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_q[$];
    logic [6:0]  font_t [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg7_scan_display #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .GHOST_GAP   (1),
        .ACTIVE_LOW  (1'b1)
`ifdef BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp_in       (dp_in),
        .blank       (blank),
        .lz_blank_en (lz_blank_en),
`ifdef BLINK_EN
        .blink       (blink),
`endif
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // dark: digits the caller expects fully unlit (blank, LZ or blink), derived by hand.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dpi, input logic [3:0] dark);
        logic [3:0] an_e;
        logic [3:0] nib;
        for (int s = 0; s < 4; s++) begin
            exp_q.push_back({4'hF, 7'h7F, 1'b1});
            an_e = ~(4'b0001 << s);
            nib  = d[4*s +: 4];
            for (int c = 1; c < 4; c++) begin
                if (dark[s]) exp_q.push_back({an_e, 7'h7F, 1'b1});
                else         exp_q.push_back({an_e, ~font_t[nib], ~dpi[s]});
            end
        end
    endtask

    // Called when the current sample is frame cycle 0.
    task automatic check_frame(input string tag, input bit chg, input logic [15:0] chg_val);
        logic [11:0] e;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) step();
            if (chg && j == 5) digits = chg_val;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL %s_queue observed=empty expected=entry", tag);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk($sformatf("%s_c%0d", tag, j), 32'({an, seg, dp}), 32'(e));
            end
            chk($sformatf("%s_fs%0d", tag, j), 32'(frame_start), 32'(j == 0));
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        step();
        while (frame_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("wait_frame", 32'(frame_start), 32'd1);
    endtask

    initial begin
        // 1. reset and first frame
        repeat (3) begin
            step();
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_dp", 32'(dp), 32'd1);
            chk("rst_fs", 32'(frame_start), 32'd0);
        end
        digits = 16'h1234;
        rst = 1'b0;
        step();
        push_frame(16'h1234, 4'b0000, 4'b0000);
        check_frame("f1234", 1'b0, 16'h0);

        // 2. mid-frame change is held off until the next boundary
        wait_frame();
        push_frame(16'h1234, 4'b0000, 4'b0000);
        check_frame("snap_old", 1'b1, 16'hABCD);
        wait_frame();
        push_frame(16'hABCD, 4'b0000, 4'b0000);
        check_frame("snap_new", 1'b0, 16'h0);

        // 3. leading-zero blanking
        digits = 16'h0070;
        lz_blank_en = 1'b1;
        wait_frame();
        push_frame(16'h0070, 4'b0000, 4'b1100);
        check_frame("lz_0070", 1'b0, 16'h0);
        digits = 16'h0000;
        wait_frame();
        push_frame(16'h0000, 4'b0000, 4'b1110);
        check_frame("lz_0000", 1'b0, 16'h0);
        dp_in = 4'b0100;
        wait_frame();
        push_frame(16'h0000, 4'b0100, 4'b1000);
        check_frame("lz_dp", 1'b0, 16'h0);

        // 4. blank overrides dp
        digits = 16'h5678;
        lz_blank_en = 1'b0;
        blank = 4'b0010;
        dp_in = 4'b0011;
        wait_frame();
        push_frame(16'h5678, 4'b0011, 4'b0010);
        check_frame("blank_dp", 1'b0, 16'h0);

        // 5. reset at cnt=2 of slot 2
        digits = 16'h1234;
        blank = 4'b0000;
        dp_in = 4'b0000;
        wait_frame();
        repeat (9) step();
        chk("pre_rst_an", 32'(an), 32'hB);
        rst = 1'b1;
        step();
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_dp", 32'(dp), 32'd1);
        chk("mid_rst_fs", 32'(frame_start), 32'd0);
        step();
        rst = 1'b0;
        step();
        push_frame(16'h1234, 4'b0000, 4'b0000);
        check_frame("post_rst", 1'b0, 16'h0);

`ifdef BLINK_EN
        // 6. blink: phase flips every 2 frames from reset
        rst = 1'b1;
        blink = 4'b0001;
        step();
        step();
        rst = 1'b0;
        step();
        for (int f = 0; f < 6; f++) begin
            if (f > 0) wait_frame();
            push_frame(16'h1234, 4'b0000, (f == 2 || f == 3) ? 4'b0001 : 4'b0000);
            check_frame($sformatf("blink_f%0d", f), 1'b0, 16'h0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
